// File: rtl/f_event_logger_pkg.sv
// Shared types and default sizing for the F-edge event logger.
// TRACE_CHANGE_EN adds a kind bit to each record (1 = F edge, 0 = state change only).
package f_log_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int TS_W_DEF  = 8;
  localparam int CNT_W_DEF = 8;
  localparam int PTR_W     = $clog2(DEPTH_DEF);

  // One logged record: state at the event plus the pre-increment timestamp.
  typedef struct packed {
`ifdef TRACE_CHANGE_EN
    logic                kind;
`endif
    logic [2:0]          state;
    logic [TS_W_DEF-1:0] ts;
  } rec_t;

endpackage

// File: rtl/f_event_logger_if.sv
// Host read port of the event logger: show-ahead valid/ready record stream.
// TRACE_CHANGE_EN adds the rd_kind field.
interface f_event_logger_if #(parameter int TS_W = 8);

  logic            rd_valid;
  logic            rd_ready;
  logic [2:0]      rd_state;
  logic [TS_W-1:0] rd_ts;
`ifdef TRACE_CHANGE_EN
  logic            rd_kind;

  modport master (output rd_valid, rd_state, rd_ts, rd_kind, input rd_ready);
  modport slave  (input rd_valid, rd_state, rd_ts, rd_kind, output rd_ready);
`else
  modport master (output rd_valid, rd_state, rd_ts, input rd_ready);
  modport slave  (input rd_valid, rd_state, rd_ts, output rd_ready);
`endif

endinterface

// File: rtl/f_event_logger_trace_fifo.sv
// Generic show-ahead FIFO. A push into a full FIFO is still accepted when a
// pop happens in the same cycle; clr empties it and blocks that cycle's push/pop.
module trace_fifo
  import f_log_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop_req,
  input  logic [WIDTH-1:0] wdata,
  output logic             accepted,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic             do_pop;

  assign valid    = (occ != '0);
  assign full     = (occ == CW'(DEPTH));
  assign do_pop   = pop_req & valid & ~clr;
  assign accepted = push & (~full | do_pop) & ~clr;

  // Head is presented combinationally; an empty FIFO shows zeros rather than stale data.
  assign rdata = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({accepted, do_pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Record storage written at the tail.
  // NOTE: storage has no reset; occupancy gates visibility, so stale words are never read.
  always_ff @(posedge clk) begin
    if (accepted) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/f_event_logger.sv
// Logs each rising edge of F as a timestamped {S, ts} record into a small FIFO,
// with a saturating event counter and a sticky overflow flag.
// Optional feature macro: TRACE_CHANGE_EN (also log changes of S, with a kind bit).
module f_event_logger
  import f_log_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             F,
  input  logic [2:0]       S,
  input  logic             en,
  input  logic             clr,
  f_event_logger_if.master rd,
  output logic [CNT_W-1:0] event_cnt,
  output logic             full,
  output logic             overflow
);

  logic            f_d;
  logic [TS_W-1:0] ts;
  logic            evt;
  logic            push;
  logic            push_ok;
  rec_t            wr_rec;
  rec_t            rd_rec;

  assign evt = en & F & ~f_d;

`ifdef TRACE_CHANGE_EN
  logic [2:0] s_d;
  logic       chg;

  assign chg         = en & (S != s_d);
  assign push        = evt | chg;
  assign wr_rec.kind = evt;
  assign rd.rd_kind  = rd_rec.kind;

  // Registered copy of S for change detection; tracks S regardless of en or clr.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) s_d <= '0;
    else        s_d <= S;
  end
`else
  assign push = evt;
`endif

  // Record carries the current S and the timestamp before this cycle's increment.
  assign wr_rec.state = S;
  assign wr_rec.ts    = ts;

  assign rd.rd_state = rd_rec.state;
  assign rd.rd_ts    = rd_rec.ts;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(rec_t))
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RESET),
    .clr      (clr),
    .push     (push),
    .pop_req  (rd.rd_ready),
    .wdata    (wr_rec),
    .accepted (push_ok),
    .rdata    (rd_rec),
    .valid    (rd.rd_valid),
    .full     (full)
  );

  // Edge-detect delay, timestamp, saturating counter and sticky overflow.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      f_d       <= 1'b0;
      ts        <= '0;
      event_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      f_d <= F;
      if (clr) begin
        ts        <= '0;
        event_cnt <= '0;
        overflow  <= 1'b0;
      end else begin
        if (en)                       ts        <= ts + TS_W'(1);
        if (evt && (event_cnt != '1)) event_cnt <= event_cnt + CNT_W'(1);
        if (push && !push_ok)         overflow  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/f_event_logger.md
Name: f_event_logger

Overview:
- Downstream consumer of the 3-bit D-flip-flop state machine.
- Watches its flag output F and state bus S, and detects each rising edge of F as an event.
- For each event, logs a timestamped record {S, timestamp} into a small FIFO, which a host drains with a valid/ready read port.
- Also keeps a saturating event counter and a sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TS_W, 8, timestamp width in bits.
- CNT_W, 8, event counter width in bits.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- F  input  1  flag from the state machine.
- S  input  3  state bus from the state machine.
- en  input  1  logging enable; when low, no events, no timestamp advance.
- clr  input  1  synchronous clear of FIFO, counter, timestamp and overflow.
- rd_ready  input  1  host accepts the head record.
- rd_valid  output  1  FIFO non-empty; head record presented.
- rd_state  output  3  S value captured at the event.
- rd_ts  output  TS_W  timestamp captured at the event.
- event_cnt  output  CNT_W  saturating count of all detected events.
- full  output  1  FIFO holds DEPTH records.
- overflow  output  1  sticky; set when an event is dropped.

Behaviour:
- Reset (RESET=0, asynchronous), all cleared: FIFO pointers, occupancy, timestamp, event_cnt, overflow and the F delay register f_d all go to 0. Hence rd_valid=0, full=0, rd_state=0, rd_ts=0.
- Timestamp ts: increments by 1 every cycle with en=1; wraps from all-ones to 0; holds when en=0.
- Event: evt = en & F & ~f_d.
  - f_d <= F every cycle, regardless of en.
  - F held high produces exactly one event.
  - F high in the first cycle after reset counts as an event.
- Push: on evt, record {S, ts} using the current-cycle S and the pre-increment ts. The record is written to the tail when accepted.
- Accept rule: push is accepted when not full, or when a pop occurs in the same cycle.
  - Full with a simultaneous pop: the push is accepted and occupancy stays DEPTH.
  - Otherwise on full: the push is dropped and overflow <= 1.
- Pop: rd_valid & rd_ready. The head advances and occupancy decrements.
  - rd_ready while empty has no effect.
- Read port is show-ahead: rd_state/rd_ts always reflect the head entry, combinationally from storage. They are stable while rd_valid=1 and rd_ready=0.
- Read latency: a record pushed in cycle N is visible (rd_valid=1) in cycle N+1.
- event_cnt: +1 on every evt, including dropped ones; saturates at all-ones.
- Pointers: log2(DEPTH) bits, wrap naturally. Occupancy counter is log2(DEPTH)+1 bits.
- full = (occupancy == DEPTH); rd_valid = (occupancy != 0).
- clr=1 takes priority over push/pop/evt in that cycle: occupancy, pointers, ts, event_cnt and overflow go to 0. f_d still updates.
- en=0: no event detection and no ts advance. Pops are still serviced.
- Mid-operation reset: all contents are discarded immediately; no partial record survives.

Optional Feature:
- Macro: TRACE_CHANGE_EN.
- Defined:
  - A second event source, chg = en & (S != s_d), with s_d a registered copy of S (reset 000).
  - A record is pushed on evt | chg. Each record gains a kind bit (1 = F edge, 0 = state change only), exposed on an extra output port rd_kind (1 bit).
  - event_cnt still counts only F-edge events.
  - Overflow applies to any dropped record.
- Not defined: only F rising edges are logged; s_d, chg and rd_kind do not exist.

Decomposition:
- Shared package f_log_pkg holds:
  - the record typedef (state[2:0], ts, optional kind);
  - the default DEPTH/TS_W/CNT_W constants;
  - the pointer-width constant derived from DEPTH.
- One sub-module, trace_fifo: generic DEPTH-entry show-ahead FIFO with push/pop, full/empty and the accept-on-simultaneous-pop rule.
- Event detection, timestamp, counter and overflow stay in f_event_logger.

Test Plan:
- Reset, then en=1, F pulses high for 3 cycles at ts=5 with S=110:
  - one record {110, 5}; rd_valid=1 the next cycle; event_cnt=1.
- Five F edges with rd_ready=0 (DEPTH=4):
  - first 4 stored in order; fifth dropped; full=1, overflow=1, event_cnt=5.
- FIFO full, F edge coincident with rd_ready=1:
  - head popped, new record accepted at tail; occupancy stays 4; overflow unchanged.
- en=0 during an F edge:
  - no record; ts frozen; event_cnt unchanged.
  - Re-enable with F still high: no event until F falls and rises again.
- Counter and timestamp saturation/wrap:
  - 255 events: event_cnt=255; the 256th event leaves event_cnt at 255.
  - ts wraps 255->0; the record after the wrap shows ts=0.
- Clear and mid-operation reset:
  - clr asserted with 2 records queued and a coincident F edge: FIFO empty, event_cnt=0, ts=0, no record pushed.
  - RESET low mid-pop: rd_valid falls immediately, asynchronously.
